// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: OV7670-style DVP transmitter test-pattern source.
// Emits vsync/href/data framing at one byte per clk, RGB565 high byte first.
// Build option: define CAM_DVP_TX_COLOR_BARS_EN to emit 8 vertical colour bars
// instead of the default per-frame incrementing pixel index. Timing is the
// same in both builds.
module cam_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int LINE_CYC = 2 * (H_ACTIVE + H_BLANK);
    localparam int HREF_CYC = 2 * H_ACTIVE;
    localparam int CW       = $clog2(LINE_CYC);
    localparam int V_MAX_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int LW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_V_BACK,
        S_ACTIVE,
        S_V_FRONT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d;
    logic [LW-1:0] last_line;
    logic          line_end;
    logic          state_end;
    logic          in_href;

    // Pattern value for the pixel shown in the next cycle.
    logic [15:0]   pat_d;

    logic          vsync_d, href_d, done_d;
    logic [7:0]    data_d;
    logic          vsync_q, href_q, done_q;
    logic [7:0]    data_q;
    logic [15:0]   frame_cnt_q;

    assign line_end  = (col_q == CW'(LINE_CYC - 1));
    assign state_end = line_end && (line_q == last_line);
    assign in_href   = (state_q == S_ACTIVE) && (col_q < CW'(HREF_CYC));

    // Last line index of the state currently being timed.
    always_comb begin
        last_line = '0;
        unique case (state_q)
            S_VSYNC:   last_line = LW'(VSYNC_LINES - 1);
            S_V_BACK:  last_line = LW'(V_BACK - 1);
            S_ACTIVE:  last_line = LW'(V_ACTIVE - 1);
            S_V_FRONT: last_line = LW'(V_FRONT - 1);
            default:   last_line = '0;
        endcase
    end

    // State and position counters.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
        end
    end

    // Next-state and counter advance; frames only start from IDLE on en.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        if (state_q == S_IDLE) begin
            col_d  = '0;
            line_d = '0;
            if (en) begin
                state_d = S_VSYNC;
            end
        end else begin
            col_d = line_end ? '0 : col_q + 1'b1;
            if (state_end) begin
                line_d = '0;
                unique case (state_q)
                    S_VSYNC:   state_d = S_V_BACK;
                    S_V_BACK:  state_d = S_ACTIVE;
                    S_ACTIVE:  state_d = S_V_FRONT;
                    S_V_FRONT: state_d = en ? S_VSYNC : S_IDLE;
                    default:   state_d = S_IDLE;
                endcase
            end else if (line_end) begin
                line_d = line_q + 1'b1;
            end
        end
    end

`ifdef CAM_DVP_TX_COLOR_BARS_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = $clog2(BAR_W + 1);

    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;

    // Bar position counters; step one bar every BAR_W pixels, cleared in blanking.
    always_comb begin
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        if (!in_href) begin
            bar_idx_d = '0;
            bar_cnt_d = '0;
        end else if (col_q[0]) begin
            if (bar_cnt_q == BW'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end
    end

    // Bar counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bar_idx_q <= '0;
            bar_cnt_q <= '0;
        end else begin
            bar_idx_q <= bar_idx_d;
            bar_cnt_q <= bar_cnt_d;
        end
    end

    // Bar colour lookup, left to right.
    always_comb begin
        pat_d = 16'h0000;
        unique case (bar_idx_d)
            3'd0: pat_d = 16'hFFFF;
            3'd1: pat_d = 16'hFFE0;
            3'd2: pat_d = 16'h07FF;
            3'd3: pat_d = 16'h07E0;
            3'd4: pat_d = 16'hF81F;
            3'd5: pat_d = 16'hF800;
            3'd6: pat_d = 16'h001F;
            3'd7: pat_d = 16'h0000;
            default: pat_d = 16'h0000;
        endcase
    end
`else
    logic [15:0] pix_q, pix_d;

    // Pixel index within the frame; advances after each low byte, zero outside ACTIVE.
    always_comb begin
        pix_d = '0;
        if (state_q == S_ACTIVE) begin
            pix_d = pix_q + {15'd0, in_href & col_q[0]};
        end
    end

    // Pixel index register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pat_d = pix_d;
`endif

    // Output decode from next-state values so the registered outputs line up
    // with the state they describe.
    always_comb begin
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && (col_d < CW'(HREF_CYC));
        data_d  = 8'h00;
        if (href_d) begin
            data_d = col_d[0] ? pat_d[7:0] : pat_d[15:8];
        end
        done_d  = (state_d == S_V_FRONT) && (col_d == CW'(LINE_CYC - 1)) &&
                  (line_d == LW'(V_FRONT - 1));
    end

    // Output registers and completed-frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            if (done_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
